// File: rtl/alu_pkg.sv
// Shared opcode values, FSM state encoding and flag bit positions for alu_seq.
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SAR = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_SIGN  = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_W     = 4;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
  endfunction
endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops with carry/overflow; shifts return a (the n=0 case),
// everything else (incl. mul) yields 0 with only zero set.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [FLG_W-1:0] flags
);
  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_sub;
  logic           w_c;
  logic           w_v;

  assign w_add = {1'b0, a} + {1'b0, b};
  // The extra top bit of the difference is the unsigned borrow (a < b).
  assign w_sub = {1'b0, a} - {1'b0, b};

  always_comb begin
    y   = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    case (op)
      OP_ADD: begin
        y   = w_add[M:0];
        w_c = w_add[WIDTH];
        w_v = (a[M] == b[M]) && (w_add[M] != a[M]);
      end
      OP_SUB: begin
        y   = w_sub[M:0];
        w_c = w_sub[WIDTH];
        w_v = (a[M] != b[M]) && (w_sub[M] != a[M]);
      end
      OP_XOR: y = a ^ b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_INC: begin
        y   = a + ONE;
        w_c = &a;
        w_v = ~a[M] & (&a[M-1:0]);
      end
      OP_DEC: begin
        y   = a - ONE;
        w_c = ~|a;
        w_v = a[M] & ~|a[M-1:0];
      end
      OP_SHL, OP_SHR, OP_SAR: y = a;
      default: ;
    endcase
  end

  always_comb begin
    flags            = '0;
    flags[FLG_ZERO]  = ~|y;
    flags[FLG_SIGN]  = y[M];
    flags[FLG_CARRY] = w_c;
    flags[FLG_OVF]   = w_v;
  end
endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: IDLE/EXEC/DONE FSM, bit-serial shifts and an
// optional shift-add multiply enabled by the ALU_SEQ_MUL_EN macro.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             sign,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);
  localparam int M     = WIDTH - 1;
  localparam int CNT_W = SHAMT_W + 1;

  state_e             r_state, w_next;
  logic [3:0]         r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_y;
  logic [FLG_W-1:0]   r_flags;

  logic [WIDTH-1:0]   w_cy;
  logic [FLG_W-1:0]   w_cflags;
  logic [SHAMT_W-1:0] w_n;
  logic               w_is_mul;
  logic               w_multi;
  logic               w_last;
  logic [WIDTH-1:0]   w_sy;
  logic               w_sc;
  logic               w_sv;
  logic [FLG_W-1:0]   w_sflags;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   w_shi;
  logic [WIDTH:0]     w_sum;
`endif

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a     (a),
    .b     (b),
    .op    (control),
    .y     (w_cy),
    .flags (w_cflags)
  );

  assign w_n = b[SHAMT_W-1:0];
`ifdef ALU_SEQ_MUL_EN
  assign w_is_mul = (control == OP_MUL);
`else
  assign w_is_mul = 1'b0;
`endif
  assign w_multi = w_is_mul || (is_shift(control) && (w_n != '0));
  assign w_last  = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = w_multi ? S_EXEC : S_DONE;
      S_EXEC:  if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One iteration step; r_y doubles as the shift register and the
  // multiplier/low-product register, so only the last step sets flags.
  always_comb begin
    w_sy = r_y;
    w_sc = 1'b0;
    w_sv = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_sum = {1'b0, r_hi} + (r_y[0] ? {1'b0, r_a} : '0);
    w_shi = w_sum[WIDTH:1];
`endif
    case (r_op)
      OP_SHL: begin w_sy = {r_y[M-1:0], 1'b0}; w_sc = r_y[M]; end
      OP_SHR: begin w_sy = {1'b0, r_y[M:1]};   w_sc = r_y[0]; end
      OP_SAR: begin w_sy = {r_y[M], r_y[M:1]}; w_sc = r_y[0]; end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        w_sy = {w_sum[0], r_y[M:1]};
        w_sc = |w_shi;
        w_sv = (w_shi != {WIDTH{w_sy[M]}});
      end
`endif
      default: ;
    endcase
    w_sflags            = '0;
    w_sflags[FLG_ZERO]  = ~|w_sy;
    w_sflags[FLG_SIGN]  = w_sy[M];
    w_sflags[FLG_CARRY] = w_sc;
    w_sflags[FLG_OVF]   = w_sv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_flags <= '0;
`ifdef ALU_SEQ_MUL_EN
      r_a     <= '0;
      r_hi    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op <= control;
          if (w_multi) begin
            r_cnt   <= w_is_mul ? CNT_W'(WIDTH) : {1'b0, w_n};
            r_y     <= w_is_mul ? b : a;
            r_flags <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_a     <= a;
            r_hi    <= '0;
`endif
          end else begin
            r_y     <= w_cy;
            r_flags <= w_cflags;
          end
        end
        S_EXEC: begin
          r_y   <= w_sy;
          r_cnt <= r_cnt - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
          r_hi  <= w_shi;
`endif
          if (w_last) r_flags <= w_sflags;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign y         = r_y;
  assign zero      = r_flags[FLG_ZERO];
  assign sign      = r_flags[FLG_SIGN];
  assign carry     = r_flags[FLG_CARRY];
  assign overflow  = r_flags[FLG_OVF];
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, a monitor pops on
// each output handshake and checks result, flags and latency.
module tb_alu_seq;
  import alu_pkg::*;
  localparam int W = 16;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, y;
  logic [3:0]   control;
  logic         zero, sign, carry, overflow, busy;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zero(zero), .sign(sign), .carry(carry),
    .overflow(overflow), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] y;
    logic z, s, c, v;
    int   lat;
    int   acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  logic bp_hold = 1'b0;
  logic seen = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t   e;
    longint ua, ub, sa, sb, r;
    int     n;
    ua = longint'(aa); ub = longint'(bb);
    sa = longint'($signed(aa)); sb = longint'($signed(bb));
    n  = int'(bb[3:0]);
    e.y = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      OP_ADD: begin r = ua + ub; e.y = r[15:0]; e.c = (r > 65535);
                    e.v = (sa + sb > 32767) || (sa + sb < -32768); end
      OP_SUB: begin r = ua - ub; e.y = r[15:0]; e.c = (ua < ub);
                    e.v = (sa - sb > 32767) || (sa - sb < -32768); end
      OP_XOR: e.y = aa ^ bb;
      OP_AND: e.y = aa & bb;
      OP_OR:  e.y = aa | bb;
      OP_INC: begin r = ua + 1; e.y = r[15:0]; e.c = (ua == 65535); e.v = (sa + 1 > 32767); end
      OP_DEC: begin r = ua - 1; e.y = r[15:0]; e.c = (ua == 0); e.v = (sa - 1 < -32768); end
      OP_SHL: begin r = ua << n; e.y = r[15:0]; e.c = (n > 0) ? r[16] : 1'b0; end
      OP_SHR: begin e.y = 16'(ua >> n); e.c = (n > 0) ? (((ua >> (n - 1)) & 1) != 0) : 1'b0; end
      OP_SAR: begin e.y = 16'(sa >>> n); e.c = (n > 0) ? (((ua >> (n - 1)) & 1) != 0) : 1'b0; end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin r = ua * ub; e.y = r[15:0]; e.c = (r > 65535); e.v = (r > 32767); e.lat = W + 1; end
`endif
      default: ;
    endcase
    if ((op == OP_SHL || op == OP_SHR || op == OP_SAR) && n > 0) e.lat = n + 1;
    e.z = (e.y == 0);
    e.s = e.y[15];
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t e;
    int   k;
    @(negedge clk);
    in_valid = 1'b1; control = op; a = aa; b = bb;
    k = 0;
    while (!in_ready && k < 300) begin @(negedge clk); k++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e = model(op, aa, bb);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin @(negedge clk); k++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    exp_t bp;
    int   k;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; control = '0; out_ready = 1'b0;

    fork
      forever begin
        @(posedge clk); #2;
        out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && out_valid && !seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) chk("spurious_output", 1, 0);
          else chk("latency", cyc - exp_q[0].acc + 1, exp_q[0].lat);
        end
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("y", y, e.y);
            chk("zero", zero, e.z);
            chk("sign", sign, e.s);
            chk("carry", carry, e.c);
            chk("overflow", overflow, e.v);
          end
          seen = 1'b0;
        end
      end
    join_none

    #3;
    chk("rst_y", y, 0);
    chk("rst_flags", {zero, sign, carry, overflow}, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // directed corner cases
    issue(OP_ADD, 16'h7FFF, 16'h0001);
    issue(OP_SUB, 16'h0003, 16'h0005);
    issue(OP_DEC, 16'h0000, 16'h0000);
    issue(OP_SAR, 16'h8010, 16'h0004);
    issue(OP_SHL, 16'h8001, 16'h0001);
    issue(OP_SHL, 16'h1234, 16'h0000);
    issue(OP_SHR, 16'hABCD, 16'h0010);
    issue(OP_SAR, 16'h8000, 16'h000F);
    issue(OP_SHR, 16'h8000, 16'h000F);
    issue(OP_INC, 16'hFFFF, 16'h0000);
    issue(OP_INC, 16'h7FFF, 16'h0000);
    issue(OP_DEC, 16'h8000, 16'h0000);
    issue(OP_SUB, 16'h8000, 16'h0001);
    issue(OP_XOR, 16'hF0F0, 16'hFF00);
    issue(OP_AND, 16'hF0F0, 16'hFF00);
    issue(OP_OR,  16'hF0F0, 16'h0F00);
    issue(OP_MUL, 16'h0100, 16'h0100);
    issue(OP_MUL, 16'h00FF, 16'h0081);
    issue(4'd15,  16'hFFFF, 16'hFFFF);
    issue(4'd11,  16'h1234, 16'h0001);
    drain();

    // backpressure: result must hold and new input must be ignored
    bp_hold = 1'b1;
    issue(OP_ADD, 16'h1234, 16'h1111);
    bp = model(OP_ADD, 16'h1234, 16'h1111);
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    chk("bp_out_valid", out_valid, 1);
    in_valid = 1'b1; control = OP_XOR; a = 16'hFFFF; b = 16'h0F0F;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_y_hold", y, bp.y);
      chk("bp_flags_hold", {zero, sign, carry, overflow}, {bp.z, bp.s, bp.c, bp.v});
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    bp_hold = 1'b0;
    drain();
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_extra", out_valid, 0);
    end

    // reset in the middle of a shift by 12
    @(negedge clk);
    chk("abort_idle", in_ready, 1);
    in_valid = 1'b1; control = OP_SHL; a = 16'h00F3; b = 16'h000C;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_busy", busy, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_y", y, 0);
    chk("abort_flags", {zero, sign, carry, overflow}, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy_clr", busy, 0);
    seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_SHR, 16'hF000, 16'h0003);
    drain();

    // randomized traffic with a bias toward edge operands
    for (int i = 0; i < 150; i++) begin
      logic [3:0]   op;
      logic [W-1:0] ra, rb;
      op = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        2: ra = 16'hFFFF;
        3: ra = 16'h0000;
        default: ;
      endcase
      issue(op, ra, rb);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
